// File: rtl/axis_pix24_pack32.sv
// axis_pix24_pack32: packs 24-bit AXIS pixels into a dense 32-bit byte stream with per-line tlast/tkeep.
// Optional start-of-frame sideband when AXIS_PIX_PACK_TUSER_EN is defined.
module axis_pix24_pack32 #(
  parameter int LINE_PIXELS = 640
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        s_axis_tvalid,
  output logic        s_axis_tready,
  input  logic [23:0] s_axis_tdata,
  output logic        m_axis_tvalid,
  input  logic        m_axis_tready,
  output logic [31:0] m_axis_tdata,
  output logic [3:0]  m_axis_tkeep,
  output logic        m_axis_tlast
`ifdef AXIS_PIX_PACK_TUSER_EN
  ,
  input  logic        s_axis_tuser,
  output logic        m_axis_tuser
`endif
);
  localparam int PCW = $clog2(LINE_PIXELS + 1);
  typedef enum logic {RUN, FLUSH} state_t;
  state_t         state;
  logic [1:0]     r;
  logic [23:0]    res;
  logic [PCW-1:0] pcnt;
  logic [47:0]    cat;
  logic           out_free, accept, eol, emit;
`ifdef AXIS_PIX_PACK_TUSER_EN
  logic           res_user;
`endif
  assign out_free      = ~m_axis_tvalid | m_axis_tready;
  assign s_axis_tready = out_free & (state == RUN);
  assign accept        = s_axis_tvalid & s_axis_tready;
  assign eol           = pcnt == PCW'(LINE_PIXELS - 1);
  // Residue bytes above r are kept zero, so OR-ing in the shifted pixel yields the byte stream.
  assign cat           = {24'h0, res} | ({24'h0, s_axis_tdata} << {r, 3'b000});
  assign emit          = accept & ((r != 2'd0) | eol);
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state         <= RUN;
      r             <= 2'd0;
      res           <= 24'h0;
      pcnt          <= '0;
      m_axis_tvalid <= 1'b0;
      m_axis_tdata  <= 32'h0;
      m_axis_tkeep  <= 4'h0;
      m_axis_tlast  <= 1'b0;
`ifdef AXIS_PIX_PACK_TUSER_EN
      res_user      <= 1'b0;
      m_axis_tuser  <= 1'b0;
`endif
    end else if (state == FLUSH) begin
      if (out_free) begin
        m_axis_tvalid <= 1'b1;
        m_axis_tdata  <= {8'h0, res};
        m_axis_tkeep  <= r == 2'd1 ? 4'h1 : 4'h3;
        m_axis_tlast  <= 1'b1;
        r             <= 2'd0;
        res           <= 24'h0;
        state         <= RUN;
`ifdef AXIS_PIX_PACK_TUSER_EN
        m_axis_tuser  <= res_user;
        res_user      <= 1'b0;
`endif
      end
    end else begin
      if (emit) begin
        m_axis_tvalid <= 1'b1;
        m_axis_tdata  <= cat[31:0];
        m_axis_tkeep  <= r == 2'd0 ? 4'h7 : 4'hF;
        m_axis_tlast  <= eol & (r <= 2'd1);
        res           <= {8'h0, cat[47:32]};
        r             <= r == 2'd0 ? 2'd0 : r - 2'd1;
        state         <= eol & r[1] ? FLUSH : RUN;
`ifdef AXIS_PIX_PACK_TUSER_EN
        m_axis_tuser  <= res_user | s_axis_tuser;
        res_user      <= 1'b0;
`endif
      end else begin
        if (m_axis_tready) m_axis_tvalid <= 1'b0;
        if (accept) begin
          res <= s_axis_tdata;
          r   <= 2'd3;
`ifdef AXIS_PIX_PACK_TUSER_EN
          res_user <= s_axis_tuser;
`endif
        end
      end
      if (accept) pcnt <= eol ? '0 : pcnt + 1'b1;
    end
  end
endmodule

// File: tb/tb_axis_pix24_pack32.sv
// tb_axis_pix24_pack32: scoreboard bench over packers with LINE_PIXELS = 2, 3, 4, 5 and 7.
module tb_axis_pix24_pack32;
  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        sv[5], sr[5], mv[5], mr[5], ml[5];
  logic [23:0] sd[5];
  logic [31:0] md[5];
  logic [3:0]  mk[5];
  int          sel = 0;
  bit          rand_ready = 1'b0;
  logic        rnd = 1'b1;
  int          compared = 0, failed = 0;
  logic [36:0] q[$];
  always #5 clk = ~clk;
  for (genvar g = 0; g < 5; g++) begin : gen_dut
    localparam int LP = g == 0 ? 2 : g == 1 ? 3 : g == 2 ? 4 : g == 3 ? 5 : 7;
    axis_pix24_pack32 #(.LINE_PIXELS(LP)) dut (
      .clk(clk), .resetn(resetn),
      .s_axis_tvalid(sv[g]), .s_axis_tready(sr[g]), .s_axis_tdata(sd[g]),
      .m_axis_tvalid(mv[g]), .m_axis_tready(mr[g]), .m_axis_tdata(md[g]),
      .m_axis_tkeep(mk[g]), .m_axis_tlast(ml[g])
    );
    assign mr[g] = (sel == g && rand_ready) ? rnd : 1'b1;
  end
  initial forever begin
    @(posedge clk);
    #1 rnd = 1'($urandom_range(0, 1));
  end
  initial begin
    logic [36:0] e, snap;
    bit stall_prev;
    stall_prev = 1'b0;
    snap = '0;
    forever begin
      @(negedge clk);
      if (!resetn) stall_prev = 1'b0;
      else begin
        if (stall_prev) begin
          compared++;
          if (!mv[sel] || {md[sel], mk[sel], ml[sel]} != snap) begin
            failed++;
            $display("FAIL stable: got v=%0b %h, required v=1 %h", mv[sel], {md[sel], mk[sel], ml[sel]}, snap);
          end
        end
        if (mv[sel] && mr[sel]) begin
          compared++;
          if (q.size() == 0) begin
            failed++;
            $display("FAIL unexpected_beat: got %h, required none", {md[sel], mk[sel], ml[sel]});
          end else begin
            e = q.pop_front();
            if ({md[sel], mk[sel], ml[sel]} !== e) begin
              failed++;
              $display("FAIL beat[dut%0d]: got data=%h keep=%h last=%b, required data=%h keep=%h last=%b",
                       sel, md[sel], mk[sel], ml[sel], e[36:5], e[4:1], e[0]);
            end
          end
        end
        stall_prev = mv[sel] && !mr[sel];
        snap = {md[sel], mk[sel], ml[sel]};
      end
    end
  end
  task automatic expect_word(input logic [31:0] d, input logic [3:0] k, input logic l);
    q.push_back({d, k, l});
  endtask
  task automatic check(input string name, input int got, input int req);
    compared++;
    if (got != req) begin
      failed++;
      $display("FAIL %s: got %0d, required %0d", name, got, req);
    end
  endtask
  task automatic send(input int i, input logic [23:0] pix, output int cyc);
    bit acc;
    cyc = 0;
    sv[i] = 1'b1;
    sd[i] = pix;
    do begin
      @(negedge clk);
      acc = sr[i];
      @(posedge clk);
      #1;
      cyc++;
    end while (!acc && cyc < 200);
    sv[i] = 1'b0;
    if (!acc) check("send_timeout", 0, 1);
  endtask
  task automatic drain();
    int n = 0;
    while (q.size() != 0 && n < 500) begin
      @(posedge clk);
      n++;
    end
    repeat (3) @(posedge clk);
    #1;
    check("drain_queue_empty", q.size(), 0);
  endtask
  initial begin
    logic [23:0] px[5];
    logic [23:0] lp[7];
    logic [7:0]  bytes[21];
    logic [31:0] w;
    logic [3:0]  k;
    int c, tot;
    for (int i = 0; i < 5; i++) begin
      sv[i] = 1'b0;
      sd[i] = 24'h0;
    end
    px[0] = 24'h030201; px[1] = 24'h060504; px[2] = 24'h090807;
    px[3] = 24'h0C0B0A; px[4] = 24'h0F0E0D;
    #12;
    for (int i = 0; i < 5; i++) begin
      check("reset_tvalid", int'(mv[i]), 0);
      check("reset_tdata", int'(md[i]), 0);
      check("reset_tkeep", int'(mk[i]), 0);
      check("reset_tlast", int'(ml[i]), 0);
      check("reset_tready", int'(sr[i]), 1);
    end
    @(posedge clk);
    #1 resetn = 1'b1;
    @(posedge clk);
    #1;
    sel = 2;
    expect_word(32'h04030201, 4'hF, 1'b0);
    expect_word(32'h08070605, 4'hF, 1'b0);
    expect_word(32'h0C0B0A09, 4'hF, 1'b1);
    tot = 0;
    for (int p = 0; p < 4; p++) begin
      send(2, px[p], c);
      tot += c;
    end
    check("lp4_no_stall_cycles", tot, 4);
    drain();
    sel = 3;
    for (int l = 0; l < 2; l++) begin
      expect_word(32'h04030201, 4'hF, 1'b0);
      expect_word(32'h08070605, 4'hF, 1'b0);
      expect_word(32'h0C0B0A09, 4'hF, 1'b0);
      expect_word(32'h000F0E0D, 4'h7, 1'b1);
      for (int p = 0; p < 5; p++) send(3, px[p], c);
    end
    drain();
    sel = 0;
    for (int l = 0; l < 2; l++) begin
      expect_word(32'h04030201, 4'hF, 1'b0);
      expect_word(32'h00000605, 4'h3, 1'b1);
    end
    send(0, px[0], c);
    send(0, px[1], c);
    send(0, px[0], c);
    check("lp2_flush_stall_cycles", c, 2);
    send(0, px[1], c);
    drain();
    sel = 1;
    expect_word(32'h04030201, 4'hF, 1'b0);
    expect_word(32'h08070605, 4'hF, 1'b0);
    expect_word(32'h00000009, 4'h1, 1'b1);
    for (int p = 0; p < 3; p++) send(1, px[p], c);
    drain();
    sel = 2;
    expect_word(32'h04030201, 4'hF, 1'b0);
    send(2, px[0], c);
    send(2, px[1], c);
    @(negedge clk);
    @(posedge clk);
    #1 resetn = 1'b0;
    #2;
    check("midline_reset_tvalid", int'(mv[2]), 0);
    check("midline_reset_tdata", int'(md[2]), 0);
    check("midline_reset_tready", int'(sr[2]), 1);
    @(posedge clk);
    #1 resetn = 1'b1;
    expect_word(32'h04030201, 4'hF, 1'b0);
    expect_word(32'h08070605, 4'hF, 1'b0);
    expect_word(32'h0C0B0A09, 4'hF, 1'b1);
    for (int p = 0; p < 4; p++) send(2, px[p], c);
    drain();
    sel = 4;
    rand_ready = 1'b1;
    for (int l = 0; l < 100; l++) begin
      for (int p = 0; p < 7; p++) begin
        lp[p] = 24'($urandom);
        for (int b = 0; b < 3; b++) bytes[3 * p + b] = lp[p][8 * b +: 8];
      end
      for (int wi = 0; wi < 6; wi++) begin
        w = 32'h0;
        k = 4'h0;
        for (int b = 0; b < 4; b++)
          if (4 * wi + b < 21) begin
            w[8 * b +: 8] = bytes[4 * wi + b];
            k[b] = 1'b1;
          end
        expect_word(w, k, wi == 5);
      end
      for (int p = 0; p < 7; p++) send(4, lp[p], c);
    end
    drain();
    rand_ready = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, failed);
    $finish;
  end
endmodule

// File: doc/axis_pix24_pack32.md
Name: axis_pix24_pack32

Overview:
- Single-clock AXI-Stream width packer. Sits directly downstream of the 24-bit async pixel FIFO, in the read-clock domain.
- Packs a stream of 24-bit pixels into a dense 32-bit byte stream, with no gaps between pixels.
- Produces per-line tlast and tkeep, so a 32-bit DMA/writer can consume whole lines.

Parameters:
- LINE_PIXELS, 640, pixels per line (>=1); tlast is asserted on the last output word of each line.
- PCW, $clog2(LINE_PIXELS+1), width of the pixel counter (derived; do not override).

Ports:
- clk  in  1  stream clock
- resetn  in  1  asynchronous, active-low reset
- s_axis_tvalid  in  1  input pixel valid
- s_axis_tready  out  1  input ready
- s_axis_tdata  in  24  pixel; byte0=[7:0], byte1=[15:8], byte2=[23:16]
- m_axis_tvalid  out  1  output word valid
- m_axis_tready  in  1  downstream ready
- m_axis_tdata  out  32  packed word; byte i = [8i+7:8i]
- m_axis_tkeep  out  4  valid byte lanes
- m_axis_tlast  out  1  last word of line

Behaviour:
- Interface (already decided): one clock, clk; reset resetn is asynchronous and active-low.
- Reset values: m_axis_tvalid=0, m_axis_tdata=0, m_axis_tkeep=0, m_axis_tlast=0. Residue count r=0, pixel count=0, state=RUN.
- s_axis_tready=1 immediately after reset.
- Byte order: the stream is little-endian. Pixel p occupies stream bytes 3p..3p+2 of the line. Output word w carries stream bytes 4w..4w+3 of the line.
- Residue register: holds up to 3 bytes, count r in {0,1,2,3}.
- A pixel is accepted when s_axis_tvalid & s_axis_tready; the available bytes are then n = r+3.
  - n>=4: load bytes[3:0] into the output register, tkeep=4'hF; r <= n-4.
  - n<4 (r=0): store the 3 bytes; r <= 3; no output.
- Output register: single stage, latency 1 cycle from accept to m_axis_tvalid.
  - Holds its contents while m_axis_tvalid & ~m_axis_tready.
  - Clears m_axis_tvalid on a handshake with no new load.
- Input ready: s_axis_tready = (~m_axis_tvalid | m_axis_tready) & (state==RUN).
- States:
  - RUN: normal packing.
  - FLUSH: a line-end residue is pending; the input is stalled.
- Line end (accepted pixel is number LINE_PIXELS), by n:
  - n=3 (r was 0): emit {8'h00, pixel}, tkeep=4'h7, tlast=1.
  - n=4 (r was 1): emit full word, tkeep=4'hF, tlast=1.
  - n=5 or 6: emit full word with tlast=0 and enter FLUSH.
- FLUSH:
  - When the output register is free or handshaking, load the residue, zero-padded: n=5 gives tkeep=4'h1, n=6 gives tkeep=4'h3; tlast=1.
  - Then r=0, return to RUN.
  - Exactly one cycle in FLUSH when m_axis_tready=1.
- Pixel counter: increments on each accept and wraps to 0 after LINE_PIXELS. r is forced to 0 at line end, so lines never share a word.
- Padding: pad bytes are always 8'h00. tkeep is always contiguous from lane 0.
- Stability: m_axis_tdata, m_axis_tkeep and m_axis_tlast are stable while m_axis_tvalid & ~m_axis_tready (AXIS rule).
- Reset mid-line: all state, residue and the output word are discarded. The next accepted pixel is pixel 0 of a new line.
- Throughput: 1 pixel/cycle sustained under m_axis_tready=1, except the FLUSH bubble at line ends with LINE_PIXELS%4 in {2,3}.

Optional Feature:
- Macro AXIS_PIX_PACK_TUSER_EN.
- When defined: adds port s_axis_tuser (in, 1, start-of-frame on a pixel) and m_axis_tuser (out, 1).
  - m_axis_tuser=1 on the output word containing byte0 of the flagged pixel; 0 otherwise.
  - The flag is stored alongside the residue when that byte is buffered.
  - If tuser arrives while pixel count!=0, it is still forwarded; counters are not realigned.
- When undefined: neither port exists, and no tuser storage is implemented.

Test Plan:
- LINE_PIXELS=4, in 0x030201, 0x060504, 0x090807, 0x0C0B0A, tready=1 -> out 0x04030201, 0x08070605, 0x0C0B0A09; tkeep=F; tlast only on the 3rd word; no stall.
- LINE_PIXELS=5, same 4 pixels plus 0x0F0E0D -> 4th word 0x000F0E0D, tkeep=7, tlast=1; next line starts with r=0.
- LINE_PIXELS=2, in 0x030201, 0x060504 -> 0x04030201 (tlast=0), then 0x00000605 (tkeep=3, tlast=1); s_axis_tready low exactly 1 cycle (FLUSH).
- LINE_PIXELS=3, 9 bytes 0x01..0x09 -> 0x04030201, 0x08070605, 0x00000009 with tkeep=1, tlast=1.
- Random m_axis_tready (50%) over 100 lines, LINE_PIXELS=7 -> byte stream matches reference model; outputs stable while stalled; no lost or duplicated beats.
- Assert resetn low after 2 pixels of a LINE_PIXELS=4 line -> tvalid=0 within the reset assertion; the next 4 pixels form a complete line with tlast on the 3rd word.
